// File: rtl/channel_fifo_ram.sv
// Simple dual-port sample store: synchronous write, registered read port.
// The read register holds its value until the next read and clears on reset.
module channel_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array; contents are deliberately left unreset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/channel_fifo.sv
// Single-clock two-channel sample FIFO for the frame-load controller.
// Pointer, occupancy, flag and sticky error logic around channel_fifo_ram.
module channel_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mux,
  input  logic                  Write,
  input  logic                  Read,
  input  logic [DATA_WIDTH-1:0] Data_Ch1,
  input  logic [DATA_WIDTH-1:0] Data_Ch2,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full_s, empty_s;
  logic                  wr_en_s, rd_en_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == '0);
  assign wr_en_s = Write & ~full_s;
  assign rd_en_s = Read & ~empty_s;
  assign wdata_s = Mux ? Data_Ch1 : Data_Ch2;

  // Next-state for pointers, occupancy, valid strobe and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = rd_en_s;
    ovf_d    = ovf_q | (Write & full_s);
    udf_d    = udf_q | (Read & empty_s);

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  channel_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .re_i    (rd_en_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (Data_Out)
  );

  assign Valid_Out = valid_q;
  assign Full      = full_s;
  assign Empty     = empty_s;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo against a queue-based reference model.
module tb_channel_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          Mux, Write, Read;
  logic [DW-1:0] Data_Ch1, Data_Ch2;
  logic [DW-1:0] Data_Out;
  logic          Valid_Out, Full, Empty, Overflow, Underflow;
  logic [AW:0]   Count;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_valid, m_ovf, m_udf;

  always #5 clk = ~clk;

  channel_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .Mux(Mux), .Write(Write), .Read(Read),
    .Data_Ch1(Data_Ch1), .Data_Ch2(Data_Ch2), .Data_Out(Data_Out),
    .Valid_Out(Valid_Out), .Full(Full), .Empty(Empty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  // Drive one cycle of stimulus from posedge+1, then advance the model.
  task automatic step(input logic w, input logic r, input logic mux,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    bit mf, me;
    mf = (mq.size() == DEPTH);
    me = (mq.size() == 0);
    Write = w; Read = r; Mux = mux; Data_Ch1 = d1; Data_Ch2 = d2;
    @(posedge clk); #1;
    m_valid = 1'b0;
    if (r && !me) begin
      m_dout  = mq.pop_front();
      m_valid = 1'b1;
    end
    if (w && !mf) mq.push_back(mux ? d1 : d2);
    if (w && mf) m_ovf = 1'b1;
    if (r && me) m_udf = 1'b1;
    Write = 1'b0; Read = 1'b0;
  endtask

  task automatic model_clear();
    mq.delete();
    m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0; Write = 1'b0; Read = 1'b0; Mux = 1'b0;
    Data_Ch1 = '0; Data_Ch2 = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({Count, Empty, Full, Valid_Out, Overflow, Underflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL reset_flags: got cnt=%0d e=%b f=%b v=%b o=%b u=%b", Count, Empty, Full, Valid_Out, Overflow, Underflow);
    end
    n_cmp++; if (Data_Out !== 8'h00) begin n_mis++; $display("FAIL reset_dout: got %h want 00", Data_Out); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    n_cmp++; if (Count !== 5'd5) begin n_mis++; $display("FAIL pre_reset_count: got %0d want 5", Count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({Count, Empty, Full, Valid_Out, Overflow, Underflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL async_reset: got cnt=%0d e=%b f=%b v=%b o=%b u=%b", Count, Empty, Full, Valid_Out, Overflow, Underflow);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_cmp++; if ({Data_Out, Valid_Out, Underflow} !== {8'h00, 1'b0, 1'b1}) begin
      n_mis++; $display("FAIL underflow_first: got d=%h v=%b u=%b want d=00 v=0 u=1", Data_Out, Valid_Out, Underflow);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, (i % 3) == 2, 1'b1, 8'($urandom), 8'($urandom));
      n_cmp++; if (Underflow !== 1'b1) begin n_mis++; $display("FAIL underflow_sticky: got %b want 1 at %0d", Underflow, i); end
      if (m_valid) begin
        n_cmp++; if (Data_Out !== m_dout) begin n_mis++; $display("FAIL underflow_data: got %h want %h", Data_Out, m_dout); end
      end
    end
    do_reset();
  endtask

  task automatic test_channel_select();
    step(1'b1, 1'b0, 1'b1, 8'hA1, 8'h55);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'hB2);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_cmp++; if ({Valid_Out, Data_Out} !== {1'b1, 8'hA1}) begin
      n_mis++; $display("FAIL chsel_first: got v=%b d=%h want v=1 d=a1", Valid_Out, Data_Out);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_cmp++; if ({Valid_Out, Data_Out} !== {1'b1, 8'hB2}) begin
      n_mis++; $display("FAIL chsel_second: got v=%b d=%h want v=1 d=b2", Valid_Out, Data_Out);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    n_cmp++; if ({Valid_Out, Data_Out, Empty} !== {1'b0, 8'hB2, 1'b1}) begin
      n_mis++; $display("FAIL chsel_hold: got v=%b d=%h e=%b want v=0 d=b2 e=1", Valid_Out, Data_Out, Empty);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'hEE, 8'(i));
      n_cmp++; if (Full !== (i == DEPTH - 1)) begin n_mis++; $display("FAIL fill_full: got %b at write %0d", Full, i); end
    end
    n_cmp++; if (Count !== 5'd16) begin n_mis++; $display("FAIL fill_count: got %0d want 16", Count); end
    step(1'b1, 1'b0, 1'b0, 8'hEE, 8'h77);
    n_cmp++; if ({Count, Overflow} !== {5'd16, 1'b1}) begin
      n_mis++; $display("FAIL fill_overflow: got cnt=%0d o=%b want 16 1", Count, Overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      n_cmp++; if ({Valid_Out, Data_Out} !== {1'b1, 8'(i)}) begin
        n_mis++; $display("FAIL drain_data: got v=%b d=%h want v=1 d=%h", Valid_Out, Data_Out, 8'(i));
      end
    end
    n_cmp++; if ({Empty, Count} !== {1'b1, 5'd0}) begin n_mis++; $display("FAIL drain_empty: got e=%b cnt=%0d", Empty, Count); end
    do_reset();
  endtask

  task automatic test_wrap();
    int lens[4] = '{10, 10, 12, 12};
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < lens[ph]; i++) begin
        step(ph % 2 == 0, ph % 2 == 1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        if (ph % 2 == 1) begin
          n_cmp++; if ({Valid_Out, Data_Out} !== {m_valid, m_dout}) begin
            n_mis++; $display("FAIL wrap_data: got v=%b d=%h want v=%b d=%h", Valid_Out, Data_Out, m_valid, m_dout);
          end
        end
      end
    end
    n_cmp++; if (Count !== 5'd0) begin n_mis++; $display("FAIL wrap_count: got %0d want 0", Count); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom), 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'($urandom), 8'h00);
      n_cmp++; if ({Count, Valid_Out, Data_Out} !== {5'd3, 1'b1, m_dout}) begin
        n_mis++; $display("FAIL simul_mid: got cnt=%0d v=%b d=%h want 3 1 %h", Count, Valid_Out, Data_Out, m_dout);
      end
    end
    while (mq.size() < DEPTH) step(1'b1, 1'b0, 1'b0, 8'h00, 8'($urandom));
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h99);
    n_cmp++; if ({Count, Overflow, Data_Out} !== {5'd15, 1'b1, m_dout}) begin
      n_mis++; $display("FAIL simul_full: got cnt=%0d o=%b d=%h want 15 1 %h", Count, Overflow, Data_Out, m_dout);
    end
    while (mq.size() > 0) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h3C, 8'h00);
    n_cmp++; if ({Count, Underflow, Valid_Out} !== {5'd1, 1'b1, 1'b0}) begin
      n_mis++; $display("FAIL simul_empty: got cnt=%0d u=%b v=%b want 1 1 0", Count, Underflow, Valid_Out);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_cmp++; if ({Valid_Out, Data_Out} !== {1'b1, 8'h3C}) begin
      n_mis++; $display("FAIL simul_empty_pop: got v=%b d=%h want 1 3c", Valid_Out, Data_Out);
    end
    do_reset();
  endtask

  task automatic test_random();
    int wp;
    for (int i = 0; i < 600; i++) begin
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      n_cmp++;
      if ({Count, Full, Empty, Valid_Out, Data_Out, Overflow, Underflow} !==
          {5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_valid, m_dout, m_ovf, m_udf}) begin
        n_mis++;
        $display("FAIL random_%0d: got cnt=%0d f=%b e=%b v=%b d=%h o=%b u=%b want cnt=%0d v=%b d=%h o=%b u=%b",
                 i, Count, Full, Empty, Valid_Out, Data_Out, Overflow, Underflow,
                 mq.size(), m_valid, m_dout, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_channel_select();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
